// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl -- game sequencer for the snake datapath.
//
// Owns the START/PLAY/PAUSE/GAME_OVER state machine, emits the one-cycle
// `update` step pulse every `step_period` frames while playing, arbitrates
// button presses into a legal pending direction that is committed to
// `direction` on each step, and counts apples into `score`.
//
// Optional feature macro: SNAKE_SPEEDUP_EN
//   defined   -> each counted apple shortens the step period by one frame
//                (floored at MIN_FRAMES), applied at the next step boundary.
//   undefined -> step_period is fixed at FRAMES_PER_STEP.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   btn_up/down/left/right  debounced one-cycle direction presses
//   btn_start    debounced one-cycle start/pause press
//   collision    00 none, 01/11 fatal, 10 apple (level)
//   update       one-cycle step pulse
//   direction    000 IDLE, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT
//   game_state   00 START, 01 PLAY, 10 PAUSE, 11 GAME_OVER
//   score        apples collected in the current game (saturating)
//   step_period  current frames per step
module snake_game_ctrl #(
    parameter int FRAMES_PER_STEP = 8,
    parameter int MIN_FRAMES      = 2,
    parameter int GAMEOVER_FRAMES = 120,
    parameter int SCORE_BITS      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_start,
    input  logic [1:0]            collision,
    output logic                  update,
    output logic [2:0]            direction,
    output logic [1:0]            game_state,
    output logic [SCORE_BITS-1:0] score,
    output logic [7:0]            step_period
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [2:0] DIR_IDLE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [7:0] PERIOD_INIT = 8'(FRAMES_PER_STEP);
    localparam logic [7:0] GO_LAST     = 8'(GAMEOVER_FRAMES - 1);
    localparam logic [SCORE_BITS-1:0] SCORE_ONE = {{(SCORE_BITS-1){1'b0}}, 1'b1};

    if (FRAMES_PER_STEP < 2 || FRAMES_PER_STEP > 255 ||
        MIN_FRAMES < 1 || MIN_FRAMES > FRAMES_PER_STEP ||
        GAMEOVER_FRAMES < 1 || GAMEOVER_FRAMES > 255) begin : g_bad_param
        $error("snake_game_ctrl: illegal parameter set");
    end

    state_t     state;
    logic [2:0] pending;
    logic [7:0] frame_cnt;
    logic [7:0] go_cnt;
    logic       apple_prev;

`ifdef SNAKE_SPEEDUP_EN
    // Period requested by the apples eaten so far; copied into step_period
    // only when the frame counter wraps so a step is never cut short.
    logic [7:0] target_period;
`endif

    logic       apple;
    logic       apple_rise;
    logic       fatal;
    logic       step_hit;
    logic       press_vld;
    logic [2:0] press_dir;

    assign game_state = state;
    assign apple      = (collision == 2'b10);
    assign apple_rise = apple && !apple_prev;
    assign fatal      = collision[0];
    assign step_hit   = frame_tick && (frame_cnt == step_period - 8'd1);

    function automatic logic is_rev(input logic [2:0] a, input logic [2:0] b);
        return (a == DIR_UP    && b == DIR_DOWN)  || (a == DIR_DOWN  && b == DIR_UP) ||
               (a == DIR_LEFT  && b == DIR_RIGHT) || (a == DIR_RIGHT && b == DIR_LEFT);
    endfunction

    // Reversals are filtered first, then the highest-priority surviving press
    // wins (later assignments override: up > down > left > right).
    always_comb begin
        press_vld = 1'b0;
        press_dir = DIR_IDLE;
        if (btn_right && !is_rev(DIR_RIGHT, direction)) begin
            press_vld = 1'b1;
            press_dir = DIR_RIGHT;
        end
        if (btn_left && !is_rev(DIR_LEFT, direction)) begin
            press_vld = 1'b1;
            press_dir = DIR_LEFT;
        end
        if (btn_down && !is_rev(DIR_DOWN, direction)) begin
            press_vld = 1'b1;
            press_dir = DIR_DOWN;
        end
        if (btn_up && !is_rev(DIR_UP, direction)) begin
            press_vld = 1'b1;
            press_dir = DIR_UP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_START;
            direction   <= DIR_IDLE;
            pending     <= DIR_IDLE;
            update      <= 1'b0;
            score       <= '0;
            step_period <= PERIOD_INIT;
            frame_cnt   <= 8'd0;
            go_cnt      <= 8'd0;
            apple_prev  <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
            target_period <= PERIOD_INIT;
`endif
        end else begin
            update     <= 1'b0;
            apple_prev <= apple;
            case (state)
                ST_START: begin
                    if (btn_start) begin
                        state       <= ST_PLAY;
                        score       <= '0;
                        frame_cnt   <= 8'd0;
                        pending     <= DIR_IDLE;
                        direction   <= DIR_IDLE;
                        step_period <= PERIOD_INIT;
`ifdef SNAKE_SPEEDUP_EN
                        target_period <= PERIOD_INIT;
`endif
                    end
                end
                ST_PLAY: begin
                    if (press_vld)
                        pending <= press_dir;
                    // A saturated score no longer counts apples, so it no
                    // longer speeds the game up either.
                    if (apple_rise && score != '1) begin
                        score <= score + SCORE_ONE;
`ifdef SNAKE_SPEEDUP_EN
                        if (target_period > 8'(MIN_FRAMES))
                            target_period <= target_period - 8'd1;
`endif
                    end
                    if (step_hit) begin
                        // The counter still wraps on a fatal step; only the
                        // pulse and the direction commit are suppressed.
                        frame_cnt <= 8'd0;
`ifdef SNAKE_SPEEDUP_EN
                        step_period <= target_period;
`endif
                        if (!fatal) begin
                            update    <= 1'b1;
                            // Commits the pending value held before this
                            // edge; a press on the step cycle lands next step.
                            direction <= pending;
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                    if (fatal) begin
                        state  <= ST_OVER;
                        go_cnt <= 8'd0;
                    end else if (btn_start) begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (btn_start)
                        state <= ST_PLAY;
                end
                ST_OVER: begin
                    if (frame_tick) begin
                        if (go_cnt == GO_LAST) begin
                            state  <= ST_START;
                            go_cnt <= 8'd0;
                        end else begin
                            go_cnt <= go_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game sequencer for the snake datapath. It owns the game state machine (start, play, pause, game over), produces the one-cycle `update` step pulse at the frame-derived step rate, and arbitrates button presses into a legal `direction` applied once per step. It also counts apples into a score and, optionally, shortens the step period as the score grows. It sits between the debounced button inputs, the VGA frame timing and the collision logic upstream, and the snake drawing/movement block downstream.

## Interface
- `FRAMES_PER_STEP`, 8: initial step period in frames; legal range 2..255.
- `MIN_FRAMES`, 2: step-period floor when speed-up is enabled; must be ≥1 and ≤FRAMES_PER_STEP.
- `GAMEOVER_FRAMES`, 120: number of frames held in GAME_OVER; range 1..255.
- `SCORE_BITS`, 8: width of the score counter.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced one-cycle press pulses.
- `btn_start` in 1: debounced one-cycle pulse for start/pause.
- `collision` in 2: level input; 00 none, 01 fatal, 10 apple, 11 fatal.
- `update` out 1: one-cycle step pulse.
- `direction` out 3: 000 IDLE, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT.
- `game_state` out 2: 00 START, 01 PLAY, 10 PAUSE, 11 GAME_OVER.
- `score` out SCORE_BITS: apples collected in the current game.
- `step_period` out 8: current frames per step.

## Operation
- Reset (`rst_n`=0 at a clk edge) sets: `game_state`=START, `direction`=IDLE, pending direction=IDLE, `update`=0, `score`=0, `step_period`=FRAMES_PER_STEP, frame counter=0, game-over counter=0, apple edge register=0.
- START:
  - `btn_start` moves to PLAY.
  - On entry to PLAY from START: clear score, frame counter and pending direction; set `direction`=IDLE; set `step_period`=FRAMES_PER_STEP.
- PLAY:
  - The frame counter increments on each `frame_tick`.
  - When a `frame_tick` arrives with counter = `step_period`−1, the counter resets to 0 and `update` pulses.
  - On that step, `direction` takes the pending direction.
- Direction arbitration:
  - A button pulse in PLAY updates the pending direction.
  - Priority for simultaneous presses: up > down > left > right.
  - A press that is the exact reverse of the current `direction` is ignored (UP/DOWN, LEFT/RIGHT). Every press is accepted while `direction`=IDLE.
  - When several presses arrive in one step period, the last accepted press wins.
  - Button presses in START, PAUSE and GAME_OVER are ignored.
- Pause:
  - `btn_start` in PLAY moves to PAUSE; `btn_start` in PAUSE moves back to PLAY.
  - In PAUSE the frame counter and pending direction are frozen and no `update` is issued.
- Apple:
  - The rising edge of (`collision`==10) in PLAY increments `score`. The score saturates at all-ones.
  - A held level counts exactly once.
- Fatal collision:
  - `collision`==01 or 11 in PLAY moves to GAME_OVER on the next edge.
  - `update` is suppressed in that same cycle.
- GAME_OVER:
  - Counts `frame_tick`s. After GAMEOVER_FRAMES ticks the state returns to START and the counter clears.
  - `score` is held, so it stays visible, until the next START→PLAY.
- Simultaneous events:
  - Fatal and `btn_start` in the same cycle: fatal wins and the state goes to GAME_OVER.
  - A step tick and a fatal collision in the same cycle: no `update`.
  - Reset asserted mid-game overrides everything in the same edge.

## Timing
- All outputs are registered.
- `update` is high for exactly one cycle: the cycle after the clk edge that samples the qualifying `frame_tick`.
- `direction` changes on the same edge that raises `update`.
- `game_state` changes one cycle after the triggering input is sampled.
- Score increments one cycle after the apple rising edge.
- At most one `update` per FRAMES_PER_STEP frames at the default period. Step spacing is exactly `step_period` frames while in PLAY.
- `step_period` changes take effect on the next step boundary. The counter compares against the new value from then on.

## Configuration
- `SNAKE_SPEEDUP_EN` defined:
  - Each counted apple decrements `step_period` by 1, floored at MIN_FRAMES.
  - The new period is applied when the frame counter next wraps.
- `SNAKE_SPEEDUP_EN` undefined:
  - `step_period` is constant at FRAMES_PER_STEP.
  - No decrement logic is synthesised.

## Test plan
- Reset, then `btn_start`, then 16 `frame_tick`s with FRAMES_PER_STEP=8 → `game_state`=01; exactly 2 `update` pulses, each 1 cycle wide, at ticks 8 and 16; `direction`=000.
- In PLAY: `btn_right`, then one step → `direction`=100. Then `btn_left` and `btn_up` in separate cycles before the next step → `direction`=001, with left rejected as a reversal.
- `collision`=10 held for 5 cycles, released, then held again → `score`=2. With `SNAKE_SPEEDUP_EN` defined, `step_period` goes 8→7→6.
- `collision`=01 coincident with a qualifying `frame_tick` → no `update`; `game_state`=11. After 120 ticks `game_state`=00 and `score` is retained; `btn_start` then clears `score` to 0.
- `btn_start` in PLAY, 20 `frame_tick`s, then `btn_start` → no `update` while in state 10; the step phase resumes from the frozen counter value.
- `rst_n`=0 for one edge mid-PLAY with `score`=3 → all outputs return to their reset values on that edge.
